cbist_controller: RTL and testbench
===================================

# cbist_controller

Circular-BIST responder for the 4-request arbiter core. On a `bist_start` pulse it seeds a 16-bit circular signature register (CSR), drives the arbiter's request inputs from the CSR, and folds the arbiter's 16-bit response vector back into the CSR for a fixed number of cycles. It then compares the result against a golden value and reports `bist_end`, `pass_fail` and `signature_out`. It sits inside `top`, between the external BIST pins and the arbiter's functional/test input mux.

## Interface
- `NCYCLES`, 1023: number of compaction cycles in RUN; legal range 1..65535.
- `SEED`, 16'hACE1: CSR value loaded in INIT.
- `GOLDEN`, 16'hCE1A: expected final signature; regenerated per build.
- `CNT_W`, $clog2(NCYCLES+1): derived width of the run counter.

Ports:
- `clock`  in  1  sole clock; rising edge.
- `reset`  in  1  synchronous, active-high.
- `bist_start`  in  1  test request; level input, edge-detected internally.
- `cut_resp`  in  16  arbiter state/output taps (grant bits plus internal flops), sampled every RUN cycle.
- `test_req`  out  4  stimulus to the arbiter request inputs; always equals `csr[3:0]`.
- `test_mode`  out  1  selects `test_req` over functional requests in `top`.
- `signature_out`  out  16  live CSR value; frozen after RUN.
- `bist_end`  out  1  high in DONE.
- `pass_fail`  out  1  1 = signature matched `GOLDEN`; valid only while `bist_end` is high.

## Operation
- Start detection: `start_p = bist_start & ~bist_start_q`. `bist_start_q` is registered and cleared by reset.
- The FSM has five states: IDLE, INIT, RUN, COMPARE, DONE.
  - IDLE: on `start_p`, go to INIT.
  - INIT: `csr <= SEED`, `cnt <= 0`, `test_mode = 1`; go to RUN.
  - RUN: `csr <= {csr[14:0], csr[15]} ^ cut_resp`, `cnt <= cnt + 1`, `test_mode = 1`. When `cnt == NCYCLES-1`, that edge performs the final update and the FSM goes to COMPARE.
  - COMPARE: `pass_fail <= (csr == GOLDEN)`, `test_mode = 0`, CSR holds; go to DONE.
  - DONE: `bist_end = 1`; CSR and `pass_fail` hold. On `start_p`, go to INIT, which clears `pass_fail`.
- `start_p` in INIT, RUN or COMPARE is ignored; a run is never restarted mid-flight.
- Arithmetic: the CSR update is a pure XOR/rotate with no carries. `cnt` never wraps, because the exit compare happens before overflow.
- Reset in any state forces IDLE. All registers are cleared on reset, and a run in progress is discarded.

## Timing
- Reset values: `csr = 16'h0000`, `signature_out = 0`, `test_req = 0`, `test_mode = 0`, `bist_end = 0`, `pass_fail = 0`, `cnt = 0`, state IDLE.
- All outputs are registered or decoded directly from state/CSR, with no combinational path from inputs.
- Edge E0 is the first edge sampling `bist_start = 1` with `bist_start_q = 0`. After E0 the FSM is in INIT. After E1 it is in RUN and `csr = SEED`.
- Edges E2..E(NCYCLES+1) perform the NCYCLES CSR updates, each using `cut_resp` sampled at that edge.
- After E(NCYCLES+1) the FSM is in COMPARE. After E(NCYCLES+2) it is in DONE, with `bist_end = 1` and `pass_fail` valid.
- `test_mode` is high from after E0 through after E(NCYCLES+1), i.e. NCYCLES+1 cycles.
- Re-trigger from DONE: `bist_end` drops on the edge after `start_p` is sampled.
- `bist_start` held high continuously produces exactly one run.

## Structure
- Shared package `cbist_pkg` holds:
  - the state enum `cbist_state_t` (IDLE, INIT, RUN, COMPARE, DONE);
  - `CBIST_W = 16` and `CBIST_REQ_W = 4`;
  - the default `SEED` and `GOLDEN` constants.
- Sub-module `cbist_csr` is the CSR register with inputs `load`, `seed`, `en`, `d` (`cut_resp`) and output `q`. The FSM, counter and comparator stay in `cbist_controller`.

## Test plan
- NCYCLES=4, `cut_resp = 0`, one-cycle `bist_start` pulse: `signature_out = 16'hCE1A`, `pass_fail = 1`, and `bist_end` rises 6 edges after the first sampled start.
- NCYCLES=1, `cut_resp = 16'h0001`, GOLDEN=16'hCE1A: final `signature_out = 16'h59C2`, `pass_fail = 0`, and `test_req = 4'h1` during RUN (`SEED[3:0]`).
- `bist_start` held high for 3000 cycles with NCYCLES=4: exactly one run; `bist_end` stays high and no second INIT occurs.
- `start_p` injected mid-RUN: ignored; the same signature and completion cycle as an unperturbed run.
- `reset` asserted mid-RUN for 1 cycle: all outputs are 0 on the next edge; a fresh start then gives the nominal result.
- Back-to-back runs, with a new pulse in DONE: `bist_end` drops one edge later, `pass_fail` clears in INIT, and the second signature is identical to the first.

Source files
------------

// File: rtl/cbist_pkg.sv
// rtl/cbist_pkg.sv - shared types and constants for the circular-BIST responder
package cbist_pkg;

    localparam int unsigned CBIST_W     = 16;
    localparam int unsigned CBIST_REQ_W = 4;

    localparam logic [CBIST_W-1:0] CBIST_SEED_DEFAULT   = 16'hACE1;
    localparam logic [CBIST_W-1:0] CBIST_GOLDEN_DEFAULT = 16'hCE1A;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_RUN     = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } cbist_state_t;

endpackage

// File: rtl/cbist_csr.sv
// rtl/cbist_csr.sv - circular signature register: rotate-left and fold in the response
module cbist_csr
    import cbist_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [CBIST_W-1:0] seed,
    input  logic               en,
    input  logic [CBIST_W-1:0] d,
    output logic [CBIST_W-1:0] q
);

    logic [CBIST_W-1:0] csr_q;
    logic [CBIST_W-1:0] csr_d;

    // Load has priority so a seed always starts from a known value.
    always_comb begin
        csr_d = csr_q;
        if (load) begin
            csr_d = seed;
        end else if (en) begin
            csr_d = {csr_q[CBIST_W-2:0], csr_q[CBIST_W-1]} ^ d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            csr_q <= '0;
        end else begin
            csr_q <= csr_d;
        end
    end

    assign q = csr_q;

endmodule

// File: rtl/cbist_controller.sv
// rtl/cbist_controller.sv - circular-BIST sequencer for the 4-request arbiter core
module cbist_controller
    import cbist_pkg::*;
#(
    parameter int unsigned        NCYCLES = 1023,
    parameter logic [CBIST_W-1:0] SEED    = CBIST_SEED_DEFAULT,
    parameter logic [CBIST_W-1:0] GOLDEN  = CBIST_GOLDEN_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   bist_start,
    input  logic [CBIST_W-1:0]     cut_resp,
    output logic [CBIST_REQ_W-1:0] test_req,
    output logic                   test_mode,
    output logic [CBIST_W-1:0]     signature_out,
    output logic                   bist_end,
    output logic                   pass_fail
);

    localparam int unsigned CNT_W = $clog2(NCYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYCLES - 1);

    cbist_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_fail_q, pass_fail_d;
    logic             bist_start_q;
    logic             start_p;
    logic             csr_load;
    logic             csr_en;
    logic [CBIST_W-1:0] csr;

    assign start_p = bist_start & ~bist_start_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pass_fail_d = pass_fail_q;
        csr_load    = 1'b0;
        csr_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_p) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                csr_load    = 1'b1;
                cnt_d       = '0;
                pass_fail_d = 1'b0;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                csr_en = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                // The final compaction happens on the same edge that leaves RUN.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                pass_fail_d = (csr == GOLDEN);
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (start_p) begin
                    state_d = ST_INIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pass_fail_q  <= 1'b0;
            bist_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pass_fail_q  <= pass_fail_d;
            bist_start_q <= bist_start;
        end
    end

    cbist_csr u_csr (
        .clock (clock),
        .reset (reset),
        .load  (csr_load),
        .seed  (SEED),
        .en    (csr_en),
        .d     (cut_resp),
        .q     (csr)
    );

    assign test_req      = csr[CBIST_REQ_W-1:0];
    assign test_mode     = (state_q == ST_INIT) || (state_q == ST_RUN);
    assign signature_out = csr;
    assign bist_end      = (state_q == ST_DONE);
    assign pass_fail     = pass_fail_q;

endmodule

// File: tb/tb_cbist_controller.sv
// tb/tb_cbist_controller.sv - directed self-checking bench for cbist_controller
module tb_cbist_controller;

    logic        clk;
    logic        rst4, start4, rst1, start1;
    logic [15:0] resp4, resp1;
    logic [3:0]  req4, req1;
    logic        tm4, tm1, end4, end1, pf4, pf1;
    logic [15:0] sig4, sig1;

    int errors = 0;
    int checks = 0;

    cbist_controller #(.NCYCLES(4)) u_dut4 (
        .clock(clk), .reset(rst4), .bist_start(start4), .cut_resp(resp4),
        .test_req(req4), .test_mode(tm4), .signature_out(sig4),
        .bist_end(end4), .pass_fail(pf4)
    );

    cbist_controller #(.NCYCLES(1), .GOLDEN(16'hCE1A)) u_dut1 (
        .clock(clk), .reset(rst1), .bist_start(start1), .cut_resp(resp1),
        .test_req(req1), .test_mode(tm1), .signature_out(sig1),
        .bist_end(end1), .pass_fail(pf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch a run on dut4 from a negedge; lat = edges from E0 to bist_end rising.
    task automatic run4(input bit hold, input int inject_at, output int lat, output int tm_cycles);
        lat = -1;
        tm_cycles = 0;
        start4 = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (tm4) tm_cycles++;
            if (k == 1) begin
                check("run_init_end_low", {31'b0, end4}, 32'd0);
                if (!hold) start4 = 1'b0;
            end
            if (k == 2) begin
                check("run_pf_cleared", {31'b0, pf4}, 32'd0);
                check("run_test_req_seed", {28'b0, req4}, 32'h1);
            end
            if (inject_at > 0 && k == inject_at) start4 = 1'b1;
            if (inject_at > 0 && k == inject_at + 1) start4 = 1'b0;
            if (end4) begin
                lat = k - 1;
                break;
            end
        end
    endtask

    int lat, tmc, extra;

    initial begin
        rst4 = 1'b1; start4 = 1'b0; resp4 = 16'h0000;
        rst1 = 1'b1; start1 = 1'b0; resp1 = 16'h0001;
        repeat (2) @(negedge clk);
        rst4 = 1'b0; rst1 = 1'b0;
        @(negedge clk);

        check("rst_sig", {16'b0, sig4}, 32'h0);
        check("rst_req", {28'b0, req4}, 32'h0);
        check("rst_tm", {31'b0, tm4}, 32'h0);
        check("rst_end", {31'b0, end4}, 32'h0);
        check("rst_pf", {31'b0, pf4}, 32'h0);

        // Nominal N=4 run with zero response: pure 4-bit rotation of the seed.
        run4(1'b0, 0, lat, tmc);
        check("nom_latency", lat, 32'd6);
        check("nom_tm_cycles", tmc, 32'd5);
        check("nom_sig", {16'b0, sig4}, 32'hCE1A);
        check("nom_pf", {31'b0, pf4}, 32'h1);

        // Back-to-back: a second pulse from DONE reruns to the same result.
        run4(1'b0, 0, lat, tmc);
        check("b2b_latency", lat, 32'd6);
        check("b2b_sig", {16'b0, sig4}, 32'hCE1A);
        check("b2b_pf", {31'b0, pf4}, 32'h1);

        // Start pulse injected mid-RUN must be ignored.
        @(negedge clk);
        run4(1'b0, 3, lat, tmc);
        check("inj_latency", lat, 32'd6);
        check("inj_sig", {16'b0, sig4}, 32'hCE1A);
        check("inj_pf", {31'b0, pf4}, 32'h1);

        // Reset mid-RUN clears everything; a fresh start then runs nominally.
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_in_run", {31'b0, tm4}, 32'h1);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        check("mrst_sig", {16'b0, sig4}, 32'h0);
        check("mrst_req", {28'b0, req4}, 32'h0);
        check("mrst_tm", {31'b0, tm4}, 32'h0);
        check("mrst_end", {31'b0, end4}, 32'h0);
        check("mrst_pf", {31'b0, pf4}, 32'h0);
        @(negedge clk);
        run4(1'b0, 0, lat, tmc);
        check("post_rst_latency", lat, 32'd6);
        check("post_rst_sig", {16'b0, sig4}, 32'hCE1A);
        check("post_rst_pf", {31'b0, pf4}, 32'h1);

        // bist_start held high: exactly one run, DONE persists.
        @(negedge clk);
        run4(1'b1, 0, lat, tmc);
        check("hold_latency", lat, 32'd6);
        extra = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!end4 || tm4) extra++;
        end
        check("hold_no_rerun", extra, 32'd0);
        check("hold_sig", {16'b0, sig4}, 32'hCE1A);
        start4 = 1'b0;

        // N=1 with response 0x0001: rotl(ACE1)^1 = 59C2, mismatches golden.
        @(negedge clk);
        check("n1_rst_sig", {16'b0, sig1}, 32'h0);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("n1_init_tm", {31'b0, tm1}, 32'h1);
        check("n1_init_end", {31'b0, end1}, 32'h0);
        @(negedge clk);
        check("n1_run_req", {28'b0, req1}, 32'h1);
        check("n1_run_sig", {16'b0, sig1}, 32'hACE1);
        @(negedge clk);
        check("n1_cmp_sig", {16'b0, sig1}, 32'h59C2);
        check("n1_cmp_tm", {31'b0, tm1}, 32'h0);
        @(negedge clk);
        check("n1_done_end", {31'b0, end1}, 32'h1);
        check("n1_done_pf", {31'b0, pf1}, 32'h0);
        check("n1_done_sig", {16'b0, sig1}, 32'h59C2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
